// File: rtl/inst_mem_loadable.sv
// rtl/inst_mem_loadable.sv - byte-addressed big-endian instruction memory with clear/load FSM and byte loader
// Optional macro INST_MEM_BOOTROM_EN: CLEAR writes a built-in boot image and goes straight to RUN.
module inst_mem_loadable #(
    parameter int DEPTH_BYTES = 32,
    parameter int PTR_W       = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC,
    input  logic        fetch_en,
    output logic [31:0] Instruction_Code,
    output logic        inst_valid,
    output logic        addr_fault,
    input  logic [7:0]  load_data,
    input  logic        load_valid,
    input  logic        load_last,
    output logic        load_ready,
    output logic        mem_ready
);

    localparam int IDX_W = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;

    localparam logic [1:0] ST_CLEAR = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH_BYTES - 1);
    localparam logic [31:0]      MAX_PC   = 32'(DEPTH_BYTES - 4);

    logic [7:0]       mem_q [DEPTH_BYTES];
    logic [1:0]       state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [31:0]      code_q, code_d;
    logic             inst_valid_q, inst_valid_d;
    logic             addr_fault_q, addr_fault_d;

    logic             mem_we;
    logic [IDX_W-1:0] mem_waddr;
    logic [7:0]       mem_wdata;
    logic             pc_legal;
    logic [IDX_W-1:0] fetch_base;

`ifdef INST_MEM_BOOTROM_EN
    function automatic logic [7:0] boot_byte(input logic [PTR_W-1:0] p);
        logic [31:0] w;
        int unsigned word_idx;
        word_idx = 32'(p) >> 2;
        case (word_idx)
            0:       w = 32'h8C01_0000;
            1:       w = 32'h0020_1020;
            2:       w = 32'h0041_1022;
            3:       w = 32'h0840_0005;
            4:       w = 32'h0041_1820;
            5:       w = 32'h0041_2020;
            6:       w = 32'hACA1_0000;
            default: w = 32'h0000_0000;
        endcase
        case (p[1:0])
            2'd0:    boot_byte = w[31:24];
            2'd1:    boot_byte = w[23:16];
            2'd2:    boot_byte = w[15:8];
            default: boot_byte = w[7:0];
        endcase
    endfunction

    // The loader port has no role once the boot image replaces LOAD.
    logic unused_loader;
    assign unused_loader = ^{load_data, load_valid, load_last};
`endif

    // Full 32-bit compare so high PC bits can never alias into the array.
    assign pc_legal   = (PC[1:0] == 2'b00) && (PC <= MAX_PC);
    assign fetch_base = PC[IDX_W-1:0];

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        mem_we       = 1'b0;
        mem_waddr    = ptr_q[IDX_W-1:0];
        mem_wdata    = 8'h00;
        code_d       = code_q;
        inst_valid_d = 1'b0;
        addr_fault_d = 1'b0;

        case (state_q)
            ST_CLEAR: begin
                mem_we = 1'b1;
`ifdef INST_MEM_BOOTROM_EN
                mem_wdata = boot_byte(ptr_q);
`else
                mem_wdata = 8'h00;
`endif
                if (ptr_q == LAST_PTR) begin
                    ptr_d = '0;
`ifdef INST_MEM_BOOTROM_EN
                    state_d = ST_RUN;
`else
                    state_d = ST_LOAD;
`endif
                end else begin
                    ptr_d = ptr_q + PTR_W'(1);
                end
            end
            ST_LOAD: begin
                if (load_valid) begin
                    mem_we    = 1'b1;
                    mem_wdata = load_data;
                    if (load_last || (ptr_q == LAST_PTR)) begin
                        state_d = ST_RUN;
                        ptr_d   = '0;
                    end else begin
                        ptr_d = ptr_q + PTR_W'(1);
                    end
                end
            end
            default: begin
            end
        endcase

        // A request in the LOAD->RUN cycle sees state_q==LOAD and is dropped.
        if ((state_q == ST_RUN) && fetch_en) begin
            inst_valid_d = 1'b1;
            if (pc_legal) begin
                code_d = {mem_q[fetch_base],
                          mem_q[{fetch_base[IDX_W-1:2], 2'b01}],
                          mem_q[{fetch_base[IDX_W-1:2], 2'b10}],
                          mem_q[{fetch_base[IDX_W-1:2], 2'b11}]};
                addr_fault_d = 1'b0;
            end else begin
                code_d       = 32'h0000_0000;
                addr_fault_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_CLEAR;
            ptr_q        <= '0;
            code_q       <= 32'h0000_0000;
            inst_valid_q <= 1'b0;
            addr_fault_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            code_q       <= code_d;
            inst_valid_q <= inst_valid_d;
            addr_fault_q <= addr_fault_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign Instruction_Code = code_q;
    assign inst_valid       = inst_valid_q;
    assign addr_fault       = addr_fault_q;
    assign load_ready       = (state_q == ST_LOAD);
    assign mem_ready        = (state_q == ST_RUN);

endmodule

// File: tb/tb_inst_mem_loadable.sv
// tb/tb_inst_mem_loadable.sv - randomized self-checking bench for inst_mem_loadable
module tb_inst_mem_loadable;

    logic        clk;
    logic        reset;
    logic [31:0] PC;
    logic        fetch_en;
    logic [31:0] Instruction_Code;
    logic        inst_valid;
    logic        addr_fault;
    logic [7:0]  load_data;
    logic        load_valid;
    logic        load_last;
    logic        load_ready;
    logic        mem_ready;

    int tests_run    = 0;
    int tests_failed = 0;

    inst_mem_loadable #(.DEPTH_BYTES(32), .PTR_W(5)) dut (
        .clk              (clk),
        .reset            (reset),
        .PC               (PC),
        .fetch_en         (fetch_en),
        .Instruction_Code (Instruction_Code),
        .inst_valid       (inst_valid),
        .addr_fault       (addr_fault),
        .load_data        (load_data),
        .load_valid       (load_valid),
        .load_last        (load_last),
        .load_ready       (load_ready),
        .mem_ready        (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the byte image, load cursor, run flag and output register.
    logic [7:0]  mm [32];
    int          model_ptr;
    bit          model_run;
    logic [31:0] model_code;
    logic [33:0] exp_out;

    function automatic bit model_legal(input logic [31:0] pc);
        longint unsigned a;
        a = longint'(pc);
        return (a % 4 == 0) && (a + 4 <= 32);
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] pc);
        int i;
        if (!model_legal(pc)) return 32'h0;
        i = int'(pc);
        return {mm[i], mm[i+1], mm[i+2], mm[i+3]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        logic [31:0] boot [7];
        boot = '{32'h8C010000, 32'h00201020, 32'h00411022, 32'h08400005,
                 32'h00411820, 32'h00412020, 32'hACA10000};
        reset = 1'b1; load_valid = 1'b0; load_last = 1'b0; fetch_en = 1'b0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 32; i++) mm[i] = 8'h00;
`ifdef INST_MEM_BOOTROM_EN
        for (int w = 0; w < 7; w++) begin
            mm[4*w]   = boot[w][31:24];
            mm[4*w+1] = boot[w][23:16];
            mm[4*w+2] = boot[w][15:8];
            mm[4*w+3] = boot[w][7:0];
        end
`endif
        model_ptr  = 0;
        model_run  = 1'b0;
        model_code = 32'h0;
    endtask

    // Counts cycles from the reset edge until the clear phase ends; flags any early ready.
    task automatic wait_clear(output int n, output bit bad);
        n = 0; bad = 1'b0;
`ifdef INST_MEM_BOOTROM_EN
        while (mem_ready !== 1'b1 && n < 100) begin
            if (load_ready !== 1'b0) bad = 1'b1;
            tick(); n++;
        end
        if (load_ready !== 1'b0) bad = 1'b1;
        model_run = 1'b1;
`else
        while (load_ready !== 1'b1 && n < 100) begin
            if (mem_ready !== 1'b0) bad = 1'b1;
            tick(); n++;
        end
        if (mem_ready !== 1'b0) bad = 1'b1;
`endif
    endtask

    task automatic send_byte(input logic [7:0] d, input bit last, input int gap);
        for (int g = 0; g < gap; g++) begin
            load_valid = 1'b0;
            load_data  = 8'($urandom);
            load_last  = 1'($urandom);
            tick();
        end
        load_valid = 1'b1; load_data = d; load_last = last;
        tick();
        load_valid = 1'b0; load_last = 1'b0;
        mm[model_ptr] = d;
        model_ptr++;
        if (last || model_ptr == 32) model_run = 1'b1;
    endtask

    task automatic fetch(input logic [31:0] pc, input bit en);
        PC = pc; fetch_en = en;
        tick();
        fetch_en = 1'b0;
        if (en && model_run) begin
            model_code = model_word(pc);
            exp_out    = {model_code, 1'b1, !model_legal(pc)};
        end else begin
            exp_out    = {model_code, 2'b00};
        end
    endtask

    task automatic test_reset();
        int n; bit bad;
        do_reset();
        tests_run++;
        if ({Instruction_Code, inst_valid, addr_fault, load_ready, mem_ready} !== 36'h0) begin
            tests_failed++;
            $display("FAIL reset_values got code=%h iv=%b af=%b lr=%b mr=%b want all 0",
                     Instruction_Code, inst_valid, addr_fault, load_ready, mem_ready);
        end
        wait_clear(n, bad);
        tests_run++;
        if (n !== 32 || bad) begin
            tests_failed++;
            $display("FAIL clear_cycles got %0d (early_ready=%b) want 32 (0)", n, bad);
        end
    endtask

    task automatic test_reset_mid_load();
        int n; bit bad;
        logic [7:0] b [3];
        for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(1, 255)), 1'b0, 0);
        do_reset();
        wait_clear(n, bad);
        tests_run++;
        if (n !== 32 || bad) begin
            tests_failed++;
            $display("FAIL midload_clear_cycles got %0d (early_ready=%b) want 32 (0)", n, bad);
        end
        for (int i = 0; i < 3; i++) begin
            b[i] = 8'($urandom_range(1, 255));
            send_byte(b[i], i == 2, 0);
        end
        fetch(32'd0, 1'b1);
        tests_run++;
        if (Instruction_Code !== {b[0], b[1], b[2], 8'h00}) begin
            tests_failed++;
            $display("FAIL midload_word0 got %h want %h", Instruction_Code, {b[0], b[1], b[2], 8'h00});
        end
        fetch(32'd4, 1'b1);
        tests_run++;
        if ({Instruction_Code, inst_valid, addr_fault} !== {32'h0, 2'b10}) begin
            tests_failed++;
            $display("FAIL midload_word1_cleared got %h/%b%b want 00000000/10",
                     Instruction_Code, inst_valid, addr_fault);
        end
    endtask

    task automatic test_load_fetch();
        int n; bit bad;
        logic [7:0] img [8];
        img = '{8'h8C, 8'h01, 8'h00, 8'h00, 8'h00, 8'h20, 8'h10, 8'h20};
        do_reset();
        wait_clear(n, bad);
        for (int i = 0; i < 7; i++) send_byte(img[i], 1'b0, 0);
        // Final byte offered together with a fetch that must be dropped.
        load_valid = 1'b1; load_data = img[7]; load_last = 1'b1;
        fetch_en = 1'b1; PC = 32'd0;
        tick();
        load_valid = 1'b0; load_last = 1'b0; fetch_en = 1'b0;
        mm[7] = img[7]; model_run = 1'b1;
        tests_run++;
        if ({mem_ready, load_ready, inst_valid} !== 3'b100) begin
            tests_failed++;
            $display("FAIL last_byte_to_run got mr=%b lr=%b iv=%b want 1 0 0",
                     mem_ready, load_ready, inst_valid);
        end
        fetch(32'd4, 1'b1);
        tests_run++;
        if ({Instruction_Code, inst_valid, addr_fault} !== {32'h00201020, 2'b10}) begin
            tests_failed++;
            $display("FAIL load_fetch_pc4 got %h/%b%b want 00201020/10",
                     Instruction_Code, inst_valid, addr_fault);
        end
        fetch(32'd0, 1'b1);
        tests_run++;
        if (Instruction_Code !== 32'h8C010000) begin
            tests_failed++;
            $display("FAIL load_fetch_pc0 got %h want 8c010000", Instruction_Code);
        end
    endtask

    task automatic test_backpressure();
        int n; bit bad; int nbytes; int errs;
        do_reset();
        wait_clear(n, bad);
        nbytes = $urandom_range(6, 20);
        bad = 1'b0;
        for (int i = 0; i < nbytes; i++) begin
            send_byte(8'($urandom), i == nbytes - 1, $urandom_range(0, 3));
            if (i < nbytes - 1 && (mem_ready !== 1'b0 || load_ready !== 1'b1)) bad = 1'b1;
        end
        tests_run++;
        if (bad || mem_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL backpressure_run_entry got early=%b mr=%b want 0 1", bad, mem_ready);
        end
        // Bytes offered in RUN must be ignored.
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            load_valid = 1'b1; load_data = 8'($urandom_range(1, 255)); load_last = 1'b0;
            tick();
            if (load_ready !== 1'b0) bad = 1'b1;
        end
        load_valid = 1'b0;
        tests_run++;
        if (bad) begin
            tests_failed++;
            $display("FAIL run_load_ready got 1 want 0");
        end
        errs = 0;
        for (int a = 0; a < 32; a += 4) begin
            fetch(32'(a), 1'b1);
            if ({Instruction_Code, inst_valid, addr_fault} !== exp_out) errs++;
        end
        tests_run++;
        if (errs != 0) begin
            tests_failed++;
            $display("FAIL backpressure_readback got %0d bad words want 0", errs);
        end
    endtask

    task automatic test_full_depth();
        int n; bit bad; int errs;
        do_reset();
        wait_clear(n, bad);
        bad = 1'b0;
        for (int i = 0; i < 32; i++) begin
            send_byte(8'($urandom), 1'b0, $urandom_range(0, 1));
            if (i < 31 && mem_ready !== 1'b0) bad = 1'b1;
        end
        tests_run++;
        if (bad || mem_ready !== 1'b1 || load_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_depth_run_entry got early=%b mr=%b lr=%b want 0 1 0",
                     bad, mem_ready, load_ready);
        end
        fetch(32'd28, 1'b1);
        tests_run++;
        if ({Instruction_Code, inst_valid, addr_fault} !== {mm[28], mm[29], mm[30], mm[31], 2'b10}) begin
            tests_failed++;
            $display("FAIL full_depth_pc28 got %h/%b%b want %h/10", Instruction_Code,
                     inst_valid, addr_fault, {mm[28], mm[29], mm[30], mm[31]});
        end
        errs = 0;
        for (int a = 0; a < 28; a += 4) begin
            fetch(32'(a), 1'b1);
            if ({Instruction_Code, inst_valid, addr_fault} !== exp_out) errs++;
        end
        tests_run++;
        if (errs != 0) begin
            tests_failed++;
            $display("FAIL full_depth_readback got %0d bad words want 0", errs);
        end
    endtask

    task automatic test_faults();
        logic [31:0] pcs [6];
        pcs = '{32'd2, 32'd32, 32'hFFFFFFFC, 32'd1, 32'd30, 32'h80000000};
        for (int i = 0; i < 6; i++) begin
            fetch(32'd0, 1'b1);
            fetch(pcs[i], 1'b1);
            tests_run++;
            if ({Instruction_Code, inst_valid, addr_fault} !== {32'h0, 2'b11}) begin
                tests_failed++;
                $display("FAIL fault_pc_%h got %h/%b%b want 00000000/11", pcs[i],
                         Instruction_Code, inst_valid, addr_fault);
            end
        end
        fetch(32'd24, 1'b1);
        fetch(32'd2, 1'b0);
        tests_run++;
        if ({Instruction_Code, inst_valid, addr_fault} !== {model_word(32'd24), 2'b00}) begin
            tests_failed++;
            $display("FAIL fetch_en_low_hold got %h/%b%b want %h/00", Instruction_Code,
                     inst_valid, addr_fault, model_word(32'd24));
        end
    endtask

    task automatic test_back_to_back();
        int errs;
        logic [31:0] pc;
        errs = 0;
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0:       pc = $urandom;
                1:       pc = 32'($urandom_range(0, 40));
                default: pc = 32'($urandom_range(0, 7) * 4);
            endcase
            fetch(pc, $urandom_range(0, 3) != 0);
            if ({Instruction_Code, inst_valid, addr_fault} !== exp_out) begin
                errs++;
                $display("FAIL back_to_back pc=%h got %h/%b%b want %h/%b%b", pc, Instruction_Code,
                         inst_valid, addr_fault, exp_out[33:2], exp_out[1], exp_out[0]);
            end
        end
        tests_run++;
        if (errs != 0) tests_failed++;
    endtask

`ifdef INST_MEM_BOOTROM_EN
    task automatic test_bootrom();
        int n; bit bad; int errs;
        do_reset();
        wait_clear(n, bad);
        tests_run++;
        if (n !== 32 || bad) begin
            tests_failed++;
            $display("FAIL boot_clear_cycles got %0d (load_ready_seen=%b) want 32 (0)", n, bad);
        end
        fetch(32'd12, 1'b1);
        tests_run++;
        if ({Instruction_Code, inst_valid, addr_fault} !== {32'h08400005, 2'b10}) begin
            tests_failed++;
            $display("FAIL boot_pc12 got %h want 08400005", Instruction_Code);
        end
        fetch(32'd24, 1'b1);
        tests_run++;
        if ({Instruction_Code, inst_valid, addr_fault} !== {32'hACA10000, 2'b10}) begin
            tests_failed++;
            $display("FAIL boot_pc24 got %h want aca10000", Instruction_Code);
        end
        errs = 0;
        for (int a = 0; a < 32; a += 4) begin
            load_valid = 1'b1; load_data = 8'hFF;
            fetch(32'(a), 1'b1);
            if ({Instruction_Code, inst_valid, addr_fault} !== exp_out || load_ready !== 1'b0) errs++;
        end
        load_valid = 1'b0;
        tests_run++;
        if (errs != 0) begin
            tests_failed++;
            $display("FAIL boot_readback got %0d bad words want 0", errs);
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; PC = 32'h0; fetch_en = 1'b0;
        load_data = 8'h0; load_valid = 1'b0; load_last = 1'b0;
        repeat (2) @(posedge clk);
        #1;
`ifdef INST_MEM_BOOTROM_EN
        test_bootrom();
        test_faults();
        test_back_to_back();
`else
        test_reset();
        test_reset_mid_load();
        test_load_fetch();
        test_backpressure();
        test_full_depth();
        test_faults();
        test_back_to_back();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
